// File: rtl/full_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package full_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : full_adder_pkg

// File: rtl/full_adder_simple.sv
// 1-bit full-adder cell; purely combinational, zero latency, no flow control.
// Clock and reset are carried on the port list so the cell drops into clocked wrappers unchanged.
module full_adder_simple (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic unused_clk_rst;

  assign unused_clk_rst = &{1'b0, clk_i, reset_n_i};

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule : full_adder_simple

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one bit per cycle, result valid WIDTH edges after accept.
// Accepts only in IDLE; holds the result in DONE until out_ready_i; clear_i aborts from any state.
module serial_adder_ctrl
  import full_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             clear_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] s_final;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             msb_cin;
  logic             accept;
  logic             last;
  logic             unused_sum_lsb;

  full_adder_simple u_fa (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .a_i       (a_sr[0]),
    .b_i       (b_sr[0]),
    .cin_i     (carry),
    .sum_o     (fa_sum),
    .cout_o    (fa_cout)
  );

  // The LSB of the sum shifter falls off on the final bit, so it is never read.
  assign s_final        = {fa_sum, s_sr[WIDTH-1:1]};
  assign unused_sum_lsb = s_sr[0];
  assign msb_cin        = carry;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    if (clear_i) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            accept    = 1'b1;
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt == CNT_LAST) begin
            last      = 1'b1;
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear_i) begin
        cnt <= '0;
      end else if (accept) begin
        a_sr  <= a_i;
        b_sr  <= b_i;
        s_sr  <= '0;
        carry <= cin_i;
        cnt   <= '0;
      end else if (state == ST_RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        s_sr  <= s_final;
        carry <= fa_cout;
        if (last) begin
          // Signed overflow: carry into the sign bit differs from carry out of it.
          sum_q  <= s_final;
          cout_q <= fa_cout;
          ovf_q  <= fa_cout ^ msb_cin;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign in_ready_o  = (state == ST_IDLE);
  assign out_valid_o = (state == ST_DONE);
  assign busy_o      = (state == ST_RUN);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

endmodule : serial_adder_ctrl
